// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential single-word reads to memory,
// buffers returned words with their PC in a 2-entry FIFO, and hands them
// to the decoder over a valid/ready handshake. A branch redirects the PC,
// flushes the buffer and discards any read still in flight.
module fetch_unit #(
  parameter logic [11:0] RESET_PC  = 12'h000,
  parameter logic [3:0]  RESET_SEG = 4'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [11:0] mem_addr,
  output logic [3:0]  mem_plus,
  output logic        mem_enable,
  output logic        mem_r_wb,
  input  logic [15:0] mem_data,
  input  logic        halt,
  input  logic        branch_valid,
  input  logic [11:0] branch_addr,
  input  logic [3:0]  branch_seg,
  output logic [15:0] instr_out,
  output logic [11:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  logic [11:0] r_pc;
  logic [3:0]  r_seg;
  logic [11:0] r_tag;
  logic        r_inflight;
  logic [15:0] r_fifo_instr [2];
  logic [11:0] r_fifo_pc    [2];
  logic        r_rd_ptr;
  logic [1:0]  r_count;

  logic        w_valid;
  logic        w_pop;
  logic [2:0]  w_occupancy;
  logic        w_issue;
  logic        w_capture;
  logic        w_wr_ptr;

  // Handshake, issue and capture decisions for the current cycle.
  always_comb begin
    w_valid     = (r_count != 2'd0);
    w_pop       = w_valid & instr_ready;
    // Slots that will be committed after this edge: buffered minus the one
    // leaving now, plus the word already on its way back from memory.
    w_occupancy = {1'b0, r_count} - {2'b00, w_pop} + {2'b00, r_inflight};
    if ((r_state == ST_RUN) && !halt && !branch_valid && (w_occupancy < 3'd2)) begin
      w_issue = 1'b1;
    end else begin
      w_issue = 1'b0;
    end
    // A branch in the same cycle kills the returning word.
    w_capture   = r_inflight & ~branch_valid;
    // Tail slot: head when empty or full, the other slot when one is held.
    w_wr_ptr    = r_rd_ptr ^ r_count[0];
  end

  // Output drive: memory request and the buffer head (zero when empty).
  always_comb begin
    mem_addr    = r_pc;
    mem_plus    = r_seg;
    mem_enable  = w_issue;
    mem_r_wb    = 1'b1;
    instr_valid = w_valid;
    if (w_valid) begin
      instr_out = r_fifo_instr[r_rd_ptr];
      instr_pc  = r_fifo_pc[r_rd_ptr];
    end else begin
      instr_out = 16'h0000;
      instr_pc  = 12'h000;
    end
  end

  // Control FSM: one idle cycle after reset release, then run until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: r_state <= ST_RUN;
        ST_RUN:  r_state <= ST_RUN;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // PC and segment: redirect on branch, otherwise advance on each issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc  <= RESET_PC;
      r_seg <= RESET_SEG;
      r_tag <= 12'h000;
    end else if (branch_valid) begin
      r_pc  <= branch_addr;
      r_seg <= branch_seg;
    end else if (w_issue) begin
      r_tag <= r_pc;
      r_pc  <= r_pc + 12'd1;   // 12-bit wrap keeps the segment unchanged
    end
  end

  // In-flight flag: set by an issue, cleared when its data returns or a branch discards it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
    end else if (branch_valid) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
    end
  end

  // Instruction FIFO storage: capture the returning word with its PC tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_fifo_instr[i] <= 16'h0000;
        r_fifo_pc[i]    <= 12'h000;
      end
    end else if (w_capture) begin
      r_fifo_instr[w_wr_ptr] <= mem_data;
      r_fifo_pc[w_wr_ptr]    <= r_tag;
    end
  end

  // FIFO pointers: pop/push bookkeeping, flushed after any coincident pop on branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (branch_valid) begin
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      r_count <= r_count + {1'b0, w_capture} - {1'b0, w_pop};
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a memory model plus a queue-based
// reference of the fetch pipeline, driven by directed and random stimulus.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] mem_addr;
  logic [3:0]  mem_plus;
  logic        mem_enable;
  logic        mem_r_wb;
  logic [15:0] mem_data = 16'h0000;
  logic        halt = 1'b0;
  logic        branch_valid = 1'b0;
  logic [11:0] branch_addr = 12'h000;
  logic [3:0]  branch_seg = 4'h0;
  logic [15:0] instr_out;
  logic [11:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;

  fetch_unit #(.RESET_PC(12'h000), .RESET_SEG(4'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_addr(mem_addr), .mem_plus(mem_plus), .mem_enable(mem_enable),
    .mem_r_wb(mem_r_wb), .mem_data(mem_data),
    .halt(halt), .branch_valid(branch_valid), .branch_addr(branch_addr),
    .branch_seg(branch_seg),
    .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  // Memory contents: word at physical address {seg, offset}.
  function automatic logic [15:0] memf(input logic [3:0] s, input logic [11:0] o);
    return 16'h1000 + {s, o};
  endfunction

  // Memory: one-cycle read latency; garbage on the bus when no read was made.
  always @(posedge clk) begin
    if (mem_enable) mem_data <= memf(mem_plus, mem_addr);
    else            mem_data <= 16'($urandom);
  end

  typedef struct {
    logic [15:0] instr;
    logic [11:0] pc;
  } ent_t;

  // Reference model state
  ent_t        m_q[$];
  bit          m_run;
  bit          m_pend;
  logic [11:0] m_pend_pc;
  logic [3:0]  m_pend_seg;
  logic [11:0] m_pc;
  logic [3:0]  m_seg;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_rd    = 0;
  logic [11:0] got_pcs[$];

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_run  = 1'b0;
    m_pend = 1'b0;
    m_pc   = 12'h000;
    m_seg  = 4'h0;
  endtask

  // Called at a negedge: asserts reset mid-cycle, checks outputs at once, releases at a negedge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk_val("rst_mem_en", mem_enable, 1'b0);
    chk_val("rst_valid", instr_valid, 1'b0);
    chk_val("rst_instr", instr_out, 16'h0000);
    chk_val("rst_ipc", instr_pc, 12'h000);
    chk_val("rst_addr", mem_addr, 12'h000);
    chk_val("rst_plus", mem_plus, 4'h0);
    chk_val("rst_r_wb", mem_r_wb, 1'b1);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock cycle, starting and ending at a negedge.
  task automatic step(input logic rdy, input logic hlt, input logic br,
                      input logic [11:0] ba, input logic [3:0] bs);
    bit          e_valid, e_pop, e_en;
    logic [15:0] e_instr;
    logic [11:0] e_ipc;
    int          occ;
    instr_ready  = rdy;
    halt         = hlt;
    branch_valid = br;
    branch_addr  = ba;
    branch_seg   = bs;
    #1;
    e_valid = (m_q.size() != 0);
    e_instr = e_valid ? m_q[0].instr : 16'h0000;
    e_ipc   = e_valid ? m_q[0].pc : 12'h000;
    e_pop   = e_valid && rdy;
    occ     = m_q.size() - (e_pop ? 1 : 0) + (m_pend ? 1 : 0);
    e_en    = m_run && !hlt && !br && (occ < 2);
    chk_val("mem_enable", mem_enable, e_en);
    chk_val("instr_valid", instr_valid, e_valid);
    chk_val("instr_out", instr_out, e_instr);
    chk_val("instr_pc", instr_pc, e_ipc);
    chk_val("mem_addr", mem_addr, m_pc);
    chk_val("mem_plus", mem_plus, m_seg);
    if (mem_enable) n_rd++;
    if (instr_valid && instr_ready) got_pcs.push_back(instr_pc);
    @(posedge clk);
    if (e_pop) void'(m_q.pop_front());
    if (br) begin
      m_q.delete();
      m_pend = 1'b0;
      m_pc   = ba;
      m_seg  = bs;
    end else begin
      if (m_pend) m_q.push_back('{instr: memf(m_pend_seg, m_pend_pc), pc: m_pend_pc});
      m_pend = e_en;
      if (e_en) begin
        m_pend_pc  = m_pc;
        m_pend_seg = m_seg;
        m_pc       = m_pc + 12'd1;
      end
    end
    m_run = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // Streaming from reset with the decoder always ready
    got_pcs.delete();
    repeat (10) step(1'b1, 1'b0, 1'b0, 12'h000, 4'h0);
    chk_val("stream_cnt", got_pcs.size(), 7);
    chk_val("stream_first", got_pcs.size() > 0 ? got_pcs[0] : 12'hFFF, 12'h000);

    // Decoder stalled from reset: exactly two reads fill the buffer
    @(negedge clk);
    do_reset();
    n_rd = 0;
    repeat (8) step(1'b0, 1'b0, 1'b0, 12'h000, 4'h0);
    chk_val("stall_reads", n_rd, 2);
    repeat (4) step(1'b1, 1'b0, 1'b0, 12'h000, 4'h0);

    // Branch with a buffered instruction and a read in flight
    step(1'b0, 1'b0, 1'b0, 12'h000, 4'h0);
    step(1'b0, 1'b1, 1'b1, 12'h0A0, 4'h2);
    #1;
    chk_val("br_flush", instr_valid, 1'b0);
    chk_val("br_seg", mem_plus, 4'h2);
    got_pcs.delete();
    repeat (6) step(1'b1, 1'b0, 1'b0, 12'h000, 4'h0);
    chk_val("br_pc", got_pcs.size() > 0 ? got_pcs[0] : 12'hFFF, 12'h0A0);

    // Branch near the top of the offset range: PC wraps, segment kept
    step(1'b1, 1'b0, 1'b1, 12'hFFE, 4'h3);
    got_pcs.delete();
    repeat (8) step(1'b1, 1'b0, 1'b0, 12'h000, 4'h0);
    chk_val("wrap_0", got_pcs.size() > 0 ? got_pcs[0] : 12'h123, 12'hFFE);
    chk_val("wrap_1", got_pcs.size() > 1 ? got_pcs[1] : 12'h123, 12'hFFF);
    chk_val("wrap_2", got_pcs.size() > 2 ? got_pcs[2] : 12'h123, 12'h000);
    chk_val("wrap_3", got_pcs.size() > 3 ? got_pcs[3] : 12'h123, 12'h001);
    chk_val("wrap_seg", mem_plus, 4'h3);

    // Halt for five cycles in steady flow
    n_rd = 0;
    repeat (5) step(1'b1, 1'b1, 1'b0, 12'h000, 4'h0);
    chk_val("halt_reads", n_rd, 0);
    step(1'b1, 1'b0, 1'b0, 12'h000, 4'h0);
    chk_val("halt_resume", n_rd, 1);
    repeat (3) step(1'b1, 1'b0, 1'b0, 12'h000, 4'h0);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
           $urandom_range(0, 19) == 0, 12'($urandom), 4'($urandom));
    end

    // Reset with a read in flight, then check nothing stale is captured
    repeat (3) step(1'b1, 1'b0, 1'b0, 12'h000, 4'h0);
    do_reset();
    got_pcs.delete();
    repeat (6) step(1'b1, 1'b0, 1'b0, 12'h000, 4'h0);
    chk_val("rst_first", got_pcs.size() > 0 ? got_pcs[0] : 12'hFFF, 12'h000);

    // More random traffic after the mid-flight reset
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0,
           $urandom_range(0, 14) == 0, 12'($urandom), 4'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
